gcd_arbiter: RTL

- Round-robin controller that shares one gcd_rtl core between NReq requesters.
- Accepts operand pairs, sequences the core's start/rdy handshake, and returns each result tagged with the requester id on a shared response bus.
- Watchdog flags a core that never completes.
- Sits between client logic and the single gcd_rtl instance.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/gcd_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gcd_pkg : shared types and helpers for the gcd_rtl sharing controller
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
package gcd_pkg;

  localparam int DEFAULT_NBITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } ctrl_state_t;

  // A single requester still needs a one-bit id field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, scanning upward from ptr
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NReq = 4
) (
  input  logic [NReq-1:0]           req,
  input  logic [id_width(NReq)-1:0] ptr,
  output logic [NReq-1:0]           grant,
  output logic [id_width(NReq)-1:0] grant_idx,
  output logic                      any
);

  localparam int IdW = id_width(NReq);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NReq; k++) begin
      if (!any && req[(int'(ptr) + k) % NReq]) begin
        any                               = 1'b1;
        grant[(int'(ptr) + k) % NReq]     = 1'b1;
        grant_idx                         = IdW'((int'(ptr) + k) % NReq);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gcd_arbiter : shares one gcd_rtl core between NReq requesters, with watchdog
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NBits         = DEFAULT_NBITS,
  parameter int NReq          = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NReq-1:0]           req_valid,
  output logic [NReq-1:0]           req_ready,
  input  logic [NReq*NBits-1:0]     req_x,
  input  logic [NReq*NBits-1:0]     req_y,
  output logic                      res_valid,
  output logic [id_width(NReq)-1:0] res_id,
  output logic [NBits-1:0]          res_data,
  output logic                      res_err,
  output logic                      busy,
  output logic                      err_sticky,
  output logic [NBits-1:0]          gcd_xi,
  output logic [NBits-1:0]          gcd_yi,
  output logic                      gcd_start,
  input  logic [NBits-1:0]          gcd_xo,
  input  logic                      gcd_rdy
);

  localparam int IdW    = id_width(NReq);
  localparam int TimerW = $clog2(TimeoutCycles) + 1;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LAUNCH = LAUNCH;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_RESP   = RESP;

  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);
  localparam logic [IdW-1:0]    LastId    = IdW'(NReq - 1);

  logic [1:0]        r_state;
  logic [IdW-1:0]    r_rr_ptr;
  logic [IdW-1:0]    r_id;
  logic [TimerW-1:0] r_timer;
  logic [NBits-1:0]  r_x;
  logic [NBits-1:0]  r_y;
  logic [NBits-1:0]  r_res_data;
  logic [IdW-1:0]    r_res_id;
  logic              r_res_err;
  logic              r_err_sticky;

  logic [NReq-1:0]   w_grant;
  logic [IdW-1:0]    w_grant_idx;
  logic              w_any;
  logic              w_accept;
  logic              w_rdy_take;
  logic              w_timeout;

  rr_arbiter #(
    .NReq (NReq)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  assign w_accept   = (r_state == S_IDLE) && w_any;
  // timer==0 marks the first WAIT cycle, where a leftover rdy must be ignored
  assign w_rdy_take = (r_state == S_WAIT) && (r_timer != '0) && gcd_rdy;
  assign w_timeout  = (r_state == S_WAIT) && !w_rdy_take && (r_timer == TimerLast);

  assign req_ready  = (r_state == S_IDLE) ? w_grant : '0;
  assign gcd_start  = (r_state == S_LAUNCH);
  assign res_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign gcd_xi     = r_x;
  assign gcd_yi     = r_y;
  assign res_data   = r_res_data;
  assign res_id     = r_res_id;
  assign res_err    = r_res_err;
  assign err_sticky = r_err_sticky;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_timer      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_res_data   <= '0;
      r_res_id     <= '0;
      r_res_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x     <= req_x[int'(w_grant_idx)*NBits +: NBits];
            r_y     <= req_y[int'(w_grant_idx)*NBits +: NBits];
            r_id    <= w_grant_idx;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_rdy_take) begin
            r_res_data <= gcd_xo;
            r_res_err  <= 1'b0;
            r_res_id   <= r_id;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_res_data   <= '0;
            r_res_err    <= 1'b1;
            r_res_id     <= r_id;
            r_err_sticky <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr_ptr <= (r_id == LastId) ? '0 : r_id + 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
